lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Load/store initiator that drives the word-addressed system RAM bus (we/addr/din/dout/wstrb, 1-cycle registered read).
//  Accepts one RV32I load/store request from the core, generates byte strobes and lane-replicated write data.
//  Waits out the RAM read latency, then aligns and sign/zero-extends load data.
//  Sits between the core execute stage and the 4KB system memory; unaligned/out-of-range accesses are faulted, never issued.
// PARAMETERS
//  AW           10  word-address width of RAM bus (1024 dwords = 4KB)
//  CHECK_RANGE  1   1: req_addr[31:AW+2] != 0 is a fault; 0: upper bits ignored
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  resetn         in   1   synchronous, active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   block can accept (high only in IDLE)
//  req_we         in   1   1=store, 0=load
//  req_funct3     in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data (LSBs significant for SB/SH)
//  rsp_valid      out  1   one-cycle completion pulse, no backpressure
//  rsp_rdata      out  32  extended load data; 0 for stores and faults
//  rsp_fault      out  1   misaligned/illegal funct3/out-of-range, valid with rsp_valid
//  mem_we         out  1   RAM write enable
//  mem_addr       out  AW  RAM word address = req_addr[AW+1:2]
//  mem_din        out  32  RAM write data
//  mem_wstrb      out  4   RAM byte-lane strobes
//  mem_dout       in   32  RAM read data, valid the cycle after mem_addr presented
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid, rsp_fault, mem_we=0; rsp_rdata, mem_addr, mem_din, mem_wstrb=0.
//  All outputs registered; req fields captured at accept edge (req_valid & req_ready); later changes ignored.
//  FSM: IDLE -> ISSUE -> (load) WAIT -> RESP -> IDLE; (store) ISSUE -> RESP; fault: IDLE -> RESP directly.
//   ISSUE: bus driven exactly one cycle; mem_we=1 only for stores; mem_addr held through WAIT.
//   WAIT: mem_dout sampled, aligned, extended into rsp_rdata.
//   RESP: rsp_valid=1 one cycle; mem_we=0, mem_wstrb=0.
//  Latency (accept edge = cycle 0): store rsp_valid in cycle 2, load in cycle 3, fault in cycle 1.
//  Throughput: one request per 3 (store) / 4 (load) cycles; req_ready low outside IDLE.
//  Store lanes (o = addr[1:0]):
//   SB: wstrb = 4'b0001<<o; din = {4{wdata[7:0]}}
//   SH: wstrb = o[1]?1100:0011; din = {2{wdata[15:0]}}
//   SW: wstrb = 1111; din = wdata
//  Load: LB/LBU select byte o; LH/LHU select half o[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passthrough.
//  Faults (no bus cycle, rsp_rdata=0):
//   - halfword with o[0]=1
//   - word with o!=0
//   - load funct3 in {011,110,111}
//   - store funct3 > 010
//   - CHECK_RANGE && upper addr bits nonzero
//  resetn low mid-op: IDLE next edge, no response emitted.
//   A store whose ISSUE cycle coincides with resetn low still commits (RAM samples that edge).
//  req_valid held high in RESP: not accepted until IDLE (the next cycle).
// STRUCTURE
//  lsu_pkg:
//   - funct3 localparams (F3_LB..F3_SW)
//   - state_t enum {IDLE,ISSUE,WAIT,RESP}
//   - function lane_strb(funct3, offset)
//  Sub-module lsu_load_align: combinational (mem_dout, funct3, offset) -> 32-bit extended data.
//  Top holds FSM, capture registers, fault check, store lane logic.
// TESTING (bench includes behavioural 1024x32 RAM with registered read address)
//  1. SW 0x12345678 @0x10, then LW @0x10 -> mem_wstrb=1111, mem_addr=4; LW rsp_rdata=0x12345678 in cycle 3.
//  2. SB 0xAB @0x13 over 0x12345678 -> wstrb=1000, din=0xABABABAB; LB @0x13 -> 0xFFFFFFAB; LBU -> 0x000000AB.
//  3. SH 0x8001 @0x22 -> wstrb=1100; LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001.
//  4. LW @0x11, LH @0x03, funct3=011 load -> rsp_fault=1 in cycle 1, rsp_rdata=0, mem_we never asserted.
//  5. LW @0x00001000 (CHECK_RANGE=1) -> fault; same address with CHECK_RANGE=0 -> reads word 0.
//  6. resetn low during WAIT -> no rsp_valid, req_ready=1 next cycle; back-to-back SW/LW with req_valid held -> exactly one accept per IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: RV32I funct3 codes,
// FSM state encoding and the store byte-lane strobe helper.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Only legal store funct3 values reach this; anything else yields no lanes.
    function automatic logic [3:0] lane_strb(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_SB:   lane_strb = 4'(4'b0001 << offset);
            F3_SH:   lane_strb = offset[1] ? 4'b1100 : 4'b0011;
            F3_SW:   lane_strb = 4'b1111;
            default: lane_strb = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/half of a RAM word and
// sign- or zero-extends it according to the RV32I load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_dout,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = mem_dout[7:0];
            2'd1:    byte_sel = mem_dout[15:8];
            2'd2:    byte_sel = mem_dout[23:16];
            default: byte_sel = mem_dout[31:24];
        endcase
        half_sel = offset[1] ? mem_dout[31:16] : mem_dout[15:0];

        case (funct3)
            F3_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  rdata = {24'h0, byte_sel};
            F3_LH:   rdata = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  rdata = {16'h0, half_sel};
            default: rdata = mem_dout;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for the word-addressed system RAM: faults bad
// requests, drives one bus cycle, waits out the read latency, returns data.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int AW          = 10,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_fault,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_dout
);

    state_t      state, next_state;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_off;
    logic        cap_we;
    logic        accept, range_fault, op_fault, req_fault, issue_store;
    logic [31:0] load_data;

    logic          d_req_ready, d_rsp_valid, d_rsp_fault, d_mem_we;
    logic [31:0]   d_rsp_rdata, d_mem_din;
    logic [AW-1:0] d_mem_addr;
    logic [3:0]    d_mem_wstrb;

    // req_ready is high only in IDLE, so accept implies state == IDLE.
    assign accept = req_valid && req_ready;

    generate
        if (CHECK_RANGE && AW < 30) begin : g_range
            assign range_fault = |req_addr[31:AW+2];
        end else begin : g_no_range
            assign range_fault = 1'b0;
        end
    endgenerate

    always_comb begin
        if (req_we) op_fault = (req_funct3 > F3_SW);
        else        op_fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        case (req_funct3[1:0])
            2'b01:   if (req_addr[0])           op_fault = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) op_fault = 1'b1;
            default: ;
        endcase
    end

    assign req_fault   = op_fault || range_fault;
    assign issue_store = accept && !req_fault && req_we;

    lsu_load_align u_align (
        .mem_dout (mem_dout),
        .funct3   (cap_funct3),
        .offset   (cap_off),
        .rdata    (load_data)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = req_fault ? RESP : ISSUE;
            ISSUE:   next_state = cap_we ? RESP : WAIT;
            WAIT:    next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs; the bus holds address/data between accesses.
    always_comb begin
        d_req_ready = (next_state == IDLE);
        d_rsp_valid = (next_state == RESP);
        d_rsp_fault = accept && req_fault;
        d_rsp_rdata = (state == WAIT) ? load_data : 32'h0;
        d_mem_we    = issue_store;
        d_mem_wstrb = issue_store ? lane_strb(req_funct3, req_addr[1:0]) : 4'b0000;
        d_mem_addr  = (accept && !req_fault) ? req_addr[AW+1:2] : mem_addr;
        d_mem_din   = mem_din;
        if (issue_store) begin
            case (req_funct3[1:0])
                2'b00:   d_mem_din = {4{req_wdata[7:0]}};
                2'b01:   d_mem_din = {2{req_wdata[15:0]}};
                default: d_mem_din = req_wdata;
            endcase
        end
    end

    // NOTE: state and output registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_fault  <= 1'b0;
            rsp_rdata  <= 32'h0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= 32'h0;
            mem_wstrb  <= 4'b0000;
            cap_funct3 <= 3'b000;
            cap_off    <= 2'b00;
            cap_we     <= 1'b0;
        end else begin
            state     <= next_state;
            req_ready <= d_req_ready;
            rsp_valid <= d_rsp_valid;
            rsp_fault <= d_rsp_fault;
            rsp_rdata <= d_rsp_rdata;
            mem_we    <= d_mem_we;
            mem_addr  <= d_mem_addr;
            mem_din   <= d_mem_din;
            mem_wstrb <= d_mem_wstrb;
            if (accept) begin
                cap_funct3 <= req_funct3;
                cap_off    <= req_addr[1:0];
                cap_we     <= req_we;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: byte-level reference memory model,
// behavioural 1024x32 RAM with registered read address, directed + random ops.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_valid2 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

    logic        req_ready, rsp_valid, rsp_fault, mem_we;
    logic [31:0] rsp_rdata, mem_din, mem_dout;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_wstrb;

    logic        req_ready2, rsp_valid2, rsp_fault2, mem_we2;
    logic [31:0] rsp_rdata2, mem_din2, mem_dout2;
    logic [9:0]  mem_addr2;
    logic [3:0]  mem_wstrb2;

    logic [31:0] ram [0:1023];
    logic [9:0]  rd_addr_q = 10'h0, rd_addr2_q = 10'h0;
    logic [7:0]  model_mem [0:4095];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.AW(10), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wstrb(mem_wstrb),
        .mem_dout(mem_dout)
    );

    lsu_mem_master #(.AW(10), .CHECK_RANGE(1'b0)) dut_norange (
        .clk(clk), .resetn(resetn), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_fault(rsp_fault2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_wstrb(mem_wstrb2),
        .mem_dout(mem_dout2)
    );

    // Behavioural RAM: byte-lane writes, read data from the address registered last edge.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int j = 0; j < 4; j++)
                if (mem_wstrb[j]) ram[mem_addr][8*j +: 8] <= mem_din[8*j +: 8];
        end
        rd_addr_q  <= mem_addr;
        rd_addr2_q <= mem_addr2;
    end
    assign mem_dout  = ram[rd_addr_q];
    assign mem_dout2 = ram[rd_addr2_q];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: little-endian byte memory, RV32I size/alignment/extension rules.
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic fault,
                                output logic [31:0] rdata, output logic [3:0] strb,
                                output logic [31:0] din);
        int size;
        int o;
        longint v;
        o = int'(addr % 4);
        case (f3 % 4)
            0:       size = 1;
            1:       size = 2;
            default: size = 4;
        endcase
        if (we) fault = (f3 > 2);
        else    fault = (f3 == 3 || f3 == 6 || f3 == 7);
        if (addr % size != 0) fault = 1'b1;
        if (addr >= 4096) fault = 1'b1;
        rdata = 32'h0;
        strb  = 4'h0;
        din   = 32'h0;
        if (!fault) begin
            if (we) begin
                for (int i = 0; i < size; i++) model_mem[addr + i] = wdata[8*i +: 8];
                strb = 4'(((1 << size) - 1) << o);
                for (int j = 0; j < 4; j++) din[8*j +: 8] = wdata[8*(j % size) +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v + (longint'(model_mem[addr + i]) << (8*i));
                if (f3 < 4 && size < 4 && v >= (64'sd1 << (8*size - 1))) v = v - (64'sd1 << (8*size));
                rdata = v[31:0];
            end
        end
    endtask

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string name, output logic [31:0] got);
        logic        e_fault;
        logic [31:0] e_rdata, e_din;
        logic [3:0]  e_strb;
        int e_lat, lat, we_cnt;
        model_access(we, f3, addr, wdata, e_fault, e_rdata, e_strb, e_din);
        e_lat = e_fault ? 1 : (we ? 2 : 3);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_before: got %b want 1", name, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom); req_we = 1'($urandom);
        lat = 0; we_cnt = 0; got = 32'h0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (mem_we === 1'b1) we_cnt++;
            if (cyc == 1) begin
                n_checks++;
                if (req_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_busy: got %b want 0", name, req_ready); end
                if (!e_fault) begin
                    n_checks++;
                    if (mem_addr !== addr[11:2]) begin n_fail++; $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, addr[11:2]); end
                    if (we) begin
                        n_checks++;
                        if (mem_wstrb !== e_strb) begin n_fail++; $display("FAIL %s wstrb: got %b want %b", name, mem_wstrb, e_strb); end
                        n_checks++;
                        if (mem_din !== e_din) begin n_fail++; $display("FAIL %s din: got %h want %h", name, mem_din, e_din); end
                    end
                end
            end
            if (rsp_valid === 1'b1) begin
                lat = cyc;
                got = rsp_rdata;
                n_checks++;
                if (rsp_fault !== e_fault) begin n_fail++; $display("FAIL %s fault: got %b want %b", name, rsp_fault, e_fault); end
                n_checks++;
                if (rsp_rdata !== e_rdata) begin n_fail++; $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, e_rdata); end
                break;
            end
        end
        n_checks++;
        if (lat != e_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, e_lat); end
        n_checks++;
        if (we_cnt != ((we && !e_fault) ? 1 : 0)) begin n_fail++; $display("FAIL %s we_cycles: got %0d want %0d", name, we_cnt, (we && !e_fault) ? 1 : 0); end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s after_rsp: valid %b ready %b want 0 1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: ready %b valid %b fault %b we %b want 1 0 0 0", req_ready, rsp_valid, rsp_fault, mem_we);
        end
        n_checks++;
        if (rsp_rdata !== 32'h0 || mem_addr !== 10'h0 || mem_din !== 32'h0 || mem_wstrb !== 4'h0) begin
            n_fail++; $display("FAIL reset_data: rdata %h addr %h din %h wstrb %b want zeros", rsp_rdata, mem_addr, mem_din, mem_wstrb);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] got;
        run_op(1'b1, F3_SW, 32'h10, 32'h12345678, "sw_10", got);
        run_op(1'b0, F3_LW, 32'h10, 32'h0, "lw_10", got);
        n_checks++;
        if (got !== 32'h12345678) begin n_fail++; $display("FAIL lw_const: got %h want 12345678", got); end
        run_op(1'b1, F3_SB, 32'h13, 32'h000000AB, "sb_13", got);
        run_op(1'b0, F3_LB, 32'h13, 32'h0, "lb_13", got);
        n_checks++;
        if (got !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL lb_const: got %h want ffffffab", got); end
        run_op(1'b0, F3_LBU, 32'h13, 32'h0, "lbu_13", got);
        n_checks++;
        if (got !== 32'h000000AB) begin n_fail++; $display("FAIL lbu_const: got %h want 000000ab", got); end
        run_op(1'b1, F3_SH, 32'h22, 32'h00008001, "sh_22", got);
        run_op(1'b0, F3_LH, 32'h22, 32'h0, "lh_22", got);
        n_checks++;
        if (got !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_const: got %h want ffff8001", got); end
        run_op(1'b0, F3_LHU, 32'h22, 32'h0, "lhu_22", got);
        n_checks++;
        if (got !== 32'h00008001) begin n_fail++; $display("FAIL lhu_const: got %h want 00008001", got); end
    endtask

    task automatic test_faults();
        logic [31:0] got;
        run_op(1'b0, F3_LW, 32'h11, 32'h0, "lw_mis", got);
        run_op(1'b0, F3_LH, 32'h03, 32'h0, "lh_mis", got);
        run_op(1'b0, 3'b011, 32'h20, 32'h0, "ld_f3_011", got);
        run_op(1'b0, 3'b111, 32'h20, 32'h0, "ld_f3_111", got);
        run_op(1'b1, 3'b100, 32'h20, 32'hDEADBEEF, "st_f3_100", got);
        run_op(1'b1, F3_SW, 32'h22, 32'hDEADBEEF, "sw_mis", got);
        run_op(1'b0, F3_LW, 32'h00001000, 32'h0, "lw_range", got);
    endtask

    task automatic test_no_range();
        logic        e_fault;
        logic [31:0] e_rdata, e_din;
        logic [3:0]  e_strb;
        int lat;
        model_access(1'b0, F3_LW, 32'h0, 32'h0, e_fault, e_rdata, e_strb, e_din);
        @(negedge clk);
        req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h00001000; req_valid2 = 1'b1;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (rsp_valid2 === 1'b1) begin
                lat = cyc;
                n_checks++;
                if (rsp_fault2 !== 1'b0 || rsp_rdata2 !== e_rdata) begin
                    n_fail++; $display("FAIL norange_lw: fault %b rdata %h want 0 %h", rsp_fault2, rsp_rdata2, e_rdata);
                end
                break;
            end
        end
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL norange_latency: got %0d want 3", lat); end
    endtask

    task automatic test_reset_mid();
        logic        e_fault;
        logic [31:0] e_rdata, e_din, got;
        logic [3:0]  e_strb;
        int spur;
        // Load aborted in WAIT: no response, ready right after reset.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_wait: ready %b valid %b want 1 0", req_ready, rsp_valid);
        end
        spur = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid === 1'b1) spur++; end
        n_checks++;
        if (spur != 0) begin n_fail++; $display("FAIL reset_wait_spurious: got %0d responses want 0", spur); end
        // Store whose ISSUE cycle sees reset still commits to RAM.
        model_access(1'b1, F3_SW, 32'h40, 32'hC0FFEE11, e_fault, e_rdata, e_strb, e_din);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h40; req_wdata = 32'hC0FFEE11; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1) begin n_fail++; $display("FAIL reset_issue_we: got %b want 1", mem_we); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_issue: valid %b ready %b we %b want 0 1 0", rsp_valid, req_ready, mem_we);
        end
        run_op(1'b0, F3_LW, 32'h40, 32'h0, "lw_after_reset", got);
    endtask

    task automatic test_back_to_back();
        logic        e_fault, pres_we;
        logic [31:0] e_rdata, e_din, pres_addr, pres_data;
        logic [3:0]  e_strb;
        logic [31:0] exp_q[$];
        int idx, last_acc, last_period, rsp_cnt;
        logic [31:0] base;
        logic        accepted;
        base = 32'($urandom_range(64, 127)) * 4;
        idx = 0; last_acc = -1; last_period = 0; rsp_cnt = 0;
        pres_we = 1'b1; pres_addr = base; pres_data = $urandom;
        @(negedge clk);
        req_we = pres_we; req_funct3 = F3_SW; req_addr = pres_addr; req_wdata = pres_data; req_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && rsp_cnt < 6; cyc++) begin
            if (cyc != 0) @(negedge clk);
            accepted = 1'b0;
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_rsp: got rdata %h want none", rsp_rdata);
                end else if (rsp_rdata !== exp_q[0] || rsp_fault !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_rsp: rdata %h fault %b want %h 0", rsp_rdata, rsp_fault, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                rsp_cnt++;
            end
            if (req_valid && req_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != last_period) begin
                        n_fail++; $display("FAIL b2b_period: got %0d want %0d", cyc - last_acc, last_period);
                    end
                end
                model_access(req_we, req_funct3, req_addr, req_wdata, e_fault, e_rdata, e_strb, e_din);
                exp_q.push_back(e_rdata);
                last_period = req_we ? 3 : 4;
                last_acc = cyc;
                accepted = 1'b1;
            end
            @(posedge clk); #1;
            if (accepted) begin
                idx++;
                if (idx < 6) begin
                    pres_we = (idx % 2 == 0);
                    pres_addr = base + 32'((idx / 2) * 4);
                    if (pres_we) pres_data = $urandom;
                    req_we = pres_we; req_funct3 = F3_LW; req_addr = pres_addr; req_wdata = pres_data;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (rsp_cnt != 6) begin n_fail++; $display("FAIL b2b_count: got %0d responses want 6", rsp_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] got, addr;
        logic [2:0]  f3;
        logic        we;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, 255));
            run_op(we, f3, addr, $urandom, "random", got);
        end
    endtask

    initial begin
        for (int w = 0; w < 1024; w++) begin
            ram[w] = $urandom;
            for (int b = 0; b < 4; b++) model_mem[4*w + b] = ram[w][8*b +: 8];
        end
        test_reset();
        test_directed();
        test_faults();
        test_no_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
